asfifo_wptr_ctrl: RTL and testbench
===================================

# asfifo_wptr_ctrl

Write-side pointer controller for the asynchronous FIFO. It accepts write requests and generates the RAM write strobe and address. It exports a glitch-free Gray write pointer to the read domain, and it synchronizes and decodes the read domain's Gray pointer to produce full, almost-full and fill level. It sits between the producer and the dual-port RAM, and is the write-domain peer of the read pointer controller.

## Interface
- AW, 4, address width; FIFO depth = 2^AW; pointers are AW+1 bits.
- AFULL_TH, 12, almost-full threshold in words; legal range 1..2^AW.
- SYNC_STAGE, 2, synchronizer flops on rd_ptr_gray; legal range ≥ 2.
- U_DLY, 1, register assignment delay for simulation.

Ports:
- clk_sys  in  1  write-domain clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  producer write request.
- rd_ptr_gray  in  AW+1  read pointer in Gray code, from the read clock domain (asynchronous to clk_sys).
- mem_we  out  1  RAM write strobe; combinational, equals wr_en & ~full.
- wr_addr  out  AW  RAM write address, equals wptr_bin[AW-1:0]; registered.
- wr_ptr_gray  out  AW+1  registered Gray write pointer, to the read-domain synchronizer.
- full  out  1  registered; FIFO holds 2^AW words.
- afull  out  1  registered; wr_level ≥ AFULL_TH.
- wr_level  out  AW+1  registered fill level as seen from the write side.
- ovf_clr  in  1  clears wr_ovf.
- wr_ovf  out  1  sticky flag for a write attempted while full.

## Operation
- Accept: accept = wr_en & ~full.
  - On accept, wptr_bin_next = wptr_bin + 1, modulo 2^(AW+1); otherwise wptr_bin_next = wptr_bin.
  - wptr_bin and wr_ptr_gray load on every edge. wr_ptr_gray = wptr_bin_next ^ (wptr_bin_next >> 1), registered, so only one bit toggles per write.
- Read-pointer path:
  - rd_ptr_gray passes through SYNC_STAGE flops. Every synchronizer flop resets to 0.
  - The last stage feeds a Gray-to-binary decoder with one output register: rptr_dec[AW] = g[AW], rptr_dec[i] = rptr_dec[i+1] ^ g[i].
- Level and flags, all registered on every edge:
  - level_next = (wptr_bin_next − rptr_dec) mod 2^(AW+1).
  - wr_level <= level_next.
  - full <= (level_next == 2^AW).
  - afull <= (level_next ≥ AFULL_TH).
- Flag behaviour:
  - Full and afull are pessimistic. They assert the cycle after the causing write and deassert only after read progress propagates through the synchronizer.
  - A write attempted while full is dropped: mem_we = 0 and pointers hold.
- Wrap-around: pointers wrap from 2^(AW+1)−1 to 0. The extra MSB distinguishes full from empty, and the subtraction stays modulo 2^(AW+1).
- Simultaneous write and read progress: both are folded into level_next on the same edge; no priority is needed.
- Reset: asynchronous. Every register and every output goes to 0 immediately, including wr_ptr_gray, wr_addr, wr_level, full, afull and wr_ovf. Reset mid-operation discards FIFO contents. The read side must be reset together with this block.

## Timing
- Write to wr_addr advance: 1 edge.
- Write to wr_level, full and afull update: 1 edge.
- rd_ptr_gray change to wr_level, full and afull update: SYNC_STAGE + 2 edges (synchronizer, decode register, level register).
- mem_we is combinational from wr_en and registered full; it carries no added latency.
- wr_ovf sets on the edge after the rejected write.

## Configuration
- ASFIFO_WR_OVF_EN defined:
  - wr_ovf sets on wr_en & full.
  - wr_ovf clears on ovf_clr; if set and clear occur on the same edge, set wins.
- ASFIFO_WR_OVF_EN undefined:
  - wr_ovf is tied to 0 and ovf_clr is ignored.
  - The ports remain present.

## Test plan
All scenarios use AW=3, AFULL_TH=6, SYNC_STAGE=2.
- Reset: assert rst_n=0 mid-stream -> all outputs 0 asynchronously; wr_level=0, full=0.
- Fill: hold rd_ptr_gray=0 and write 8 consecutive cycles -> wr_addr walks 0..7; afull=1 after the 6th write; full=1 after the 8th; wr_level=8; a 9th wr_en gives mem_we=0 and wr_addr stays 0.
- Drain visibility: from full, set rd_ptr_gray to gray(3)=4'b0010 -> full=0 and wr_level=5 exactly 4 edges later; afull=0 on the same edge.
- Wrap: perform 20 accepted writes with the reader tracking -> wr_ptr_gray changes exactly 1 bit per write; the pointer wraps 15→0 and wr_level never exceeds 8.
- Simultaneous: at wr_level=4, write while rd_ptr_gray advances by 1 -> wr_level returns to 4 once the read change has propagated; no transient full.
- Overflow (ASFIFO_WR_OVF_EN): wr_en while full -> wr_ovf=1 next edge; ovf_clr together with another rejected write keeps wr_ovf=1; ovf_clr alone clears it to 0. With the macro undefined, wr_ovf stays 0 throughout.

Source files
------------

// File: rtl/asfifo_wptr_ctrl.sv
// Write-side pointer controller for the asynchronous FIFO: write strobe/address, Gray pointer export,
// read-pointer synchronizer and full/afull/level flags. `define ASFIFO_WR_OVF_EN enables the sticky wr_ovf flag.
module asfifo_wptr_ctrl #(
  parameter int AW         = 4,
  parameter int AFULL_TH   = 12,
  parameter int SYNC_STAGE = 2,
  parameter int U_DLY      = 1
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW:0]   rd_ptr_gray,
  output logic          mem_we,
  output logic [AW-1:0] wr_addr,
  output logic [AW:0]   wr_ptr_gray,
  output logic          full,
  output logic          afull,
  output logic [AW:0]   wr_level,
  input  logic          ovf_clr,
  output logic          wr_ovf
);

  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] FULL_LVL  = (AW+1)'(2**AW);
  localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_TH);

  if (AW < 1 || SYNC_STAGE < 2 || AFULL_TH < 1 || AFULL_TH > 2**AW || U_DLY < 0) begin : g_param_chk
    $error("asfifo_wptr_ctrl: illegal parameter set");
  end

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [AW:0] wptr_bin_q, wptr_bin_d;
  logic [AW:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [AW:0] rsync_q [SYNC_STAGE];
  logic [AW:0] rsync_d [SYNC_STAGE];
  logic [AW:0] rptr_dec_q, rptr_dec_d;
  logic [AW:0] wr_level_q, wr_level_d;
  logic        full_q, full_d;
  logic        afull_q, afull_d;
  logic        accept;

  always_comb begin
    accept        = wr_en & ~full_q;
    wptr_bin_d    = accept ? (wptr_bin_q + PTR_ONE) : wptr_bin_q;
    wr_ptr_gray_d = bin2gray(wptr_bin_d);
    // Read pointer crosses into this domain only as Gray code, one flop per stage
    rsync_d[0]    = rd_ptr_gray;
    for (int i = 1; i < SYNC_STAGE; i++) rsync_d[i] = rsync_q[i-1];
    rptr_dec_d    = gray2bin(rsync_q[SYNC_STAGE-1]);
    // Level uses the post-write pointer so a write is visible on the very next edge
    wr_level_d    = wptr_bin_d - rptr_dec_q;
    full_d        = (wr_level_d == FULL_LVL);
    afull_d       = (wr_level_d >= AFULL_LVL);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wptr_bin_q    <= '0;
      wr_ptr_gray_q <= '0;
      for (int i = 0; i < SYNC_STAGE; i++) rsync_q[i] <= '0;
      rptr_dec_q    <= '0;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      afull_q       <= 1'b0;
    end else begin
      wptr_bin_q    <= wptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      rsync_q       <= rsync_d;
      rptr_dec_q    <= rptr_dec_d;
      wr_level_q    <= wr_level_d;
      full_q        <= full_d;
      afull_q       <= afull_d;
    end
  end

  // Strobe is forced low while reset is held so no RAM write can slip through
  assign mem_we      = wr_en & ~full_q & rst_n;
  assign wr_addr     = wptr_bin_q[AW-1:0];
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign full        = full_q;
  assign afull       = afull_q;
  assign wr_level    = wr_level_q;

`ifdef ASFIFO_WR_OVF_EN
  logic wr_ovf_q, wr_ovf_d;

  always_comb begin
    wr_ovf_d = wr_ovf_q;
    if (ovf_clr) wr_ovf_d = 1'b0;
    if (wr_en & full_q) wr_ovf_d = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) wr_ovf_q <= 1'b0;
    else        wr_ovf_q <= wr_ovf_d;
  end

  assign wr_ovf = wr_ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign wr_ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_asfifo_wptr_ctrl.sv
// Self-checking bench for asfifo_wptr_ctrl (AW=3, AFULL_TH=6, SYNC_STAGE=2) against a word-count reference model.
module tb_asfifo_wptr_ctrl;
  localparam int AW         = 3;
  localparam int AFULL_TH   = 6;
  localparam int SYNC_STAGE = 2;
  localparam int DEPTH      = 8;
`ifdef ASFIFO_WR_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic          clk_sys = 1'b0;
  logic          rst_n   = 1'b1;
  logic          wr_en   = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [AW:0]   rd_ptr_gray = '0;
  logic          mem_we, full, afull, wr_ovf;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_ptr_gray, wr_level;

  int checks = 0;
  int errors = 0;

  // Reference model: total words written/read as plain counts
  int wcnt, rcnt, m_level;
  bit m_full, m_afull, m_ovf;
  int rdq[$];

  asfifo_wptr_ctrl #(.AW(AW), .AFULL_TH(AFULL_TH), .SYNC_STAGE(SYNC_STAGE), .U_DLY(1)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .wr_en(wr_en), .rd_ptr_gray(rd_ptr_gray),
    .mem_we(mem_we), .wr_addr(wr_addr), .wr_ptr_gray(wr_ptr_gray), .full(full),
    .afull(afull), .wr_level(wr_level), .ovf_clr(ovf_clr), .wr_ovf(wr_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [AW:0] gray_of(input int n);
    int b = n % 16;
    return (AW+1)'(b ^ (b >> 1));
  endfunction

  task automatic model_reset();
    wcnt = 0; rcnt = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
    rdq.delete();
    repeat (SYNC_STAGE + 1) rdq.push_back(0);
  endtask

  task automatic drive(input bit w, input bit c);
    wr_en       = w;
    ovf_clr     = c;
    rd_ptr_gray = gray_of(rcnt);
    #1;
  endtask

  task automatic tick();
    int rused;
    @(posedge clk_sys);
    if (OVF_ON) begin
      if (wr_en && m_full) m_ovf = 1;
      else if (ovf_clr)    m_ovf = 0;
    end
    if (wr_en && !m_full) wcnt++;
    rdq.push_back(rcnt);
    rused   = rdq.pop_front();
    m_level = wcnt - rused;
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= AFULL_TH);
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    drive(0, 0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, wr_addr, wr_ptr_gray, full, afull, wr_level, wr_ovf} !== '0) begin
      errors++; $display("FAIL reset_initial got %b exp 0", {mem_we, wr_addr, wr_ptr_gray, full, afull, wr_level, wr_ovf});
    end
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0);
      tick();
    end
    checks++;
    if (wr_level !== 4'(m_level)) begin
      errors++; $display("FAIL reset_prefill_level got %0d exp %0d", wr_level, m_level);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, wr_addr, wr_ptr_gray, full, afull, wr_level, wr_ovf} !== '0) begin
      errors++; $display("FAIL reset_async got %b exp 0", {mem_we, wr_addr, wr_ptr_gray, full, afull, wr_level, wr_ovf});
    end
    checks++;
    if (wr_level !== 4'd0 || full !== 1'b0) begin
      errors++; $display("FAIL reset_level_full got %0d/%b exp 0/0", wr_level, full);
    end
    @(negedge clk_sys);
    rst_n = 1'b1;
    model_reset();
    drive(0, 0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0);
      checks++;
      if (wr_addr !== 3'(i) || mem_we !== 1'b1) begin
        errors++; $display("FAIL fill_addr[%0d] got addr %0d we %b exp addr %0d we 1", i, wr_addr, mem_we, i);
      end
      tick();
      checks++;
      if (wr_level !== 4'(i + 1) || afull !== (i + 1 >= 6) || full !== (i == 7)) begin
        errors++; $display("FAIL fill_flags[%0d] got lvl %0d af %b f %b exp lvl %0d af %b f %b",
                           i, wr_level, afull, full, i + 1, (i + 1 >= 6), (i == 7));
      end
    end
    drive(1, 0);
    checks++;
    if (mem_we !== 1'b0 || wr_addr !== 3'd0) begin
      errors++; $display("FAIL fill_reject got we %b addr %0d exp we 0 addr 0", mem_we, wr_addr);
    end
    tick();
    checks++;
    if (wr_addr !== 3'd0 || full !== 1'b1 || wr_level !== 4'd8) begin
      errors++; $display("FAIL fill_hold got addr %0d f %b lvl %0d exp 0 1 8", wr_addr, full, wr_level);
    end
  endtask

  task automatic test_overflow();
    drive(0, 1);
    tick();
    checks++;
    if (wr_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_preclear got %b exp 0", wr_ovf);
    end
    drive(1, 0);
    tick();
    checks++;
    if (wr_ovf !== OVF_ON || wr_addr !== 3'd0) begin
      errors++; $display("FAIL ovf_set got ovf %b addr %0d exp ovf %b addr 0", wr_ovf, wr_addr, OVF_ON);
    end
    drive(1, 1);
    tick();
    checks++;
    if (wr_ovf !== OVF_ON) begin
      errors++; $display("FAIL ovf_set_wins got %b exp %b", wr_ovf, OVF_ON);
    end
    drive(0, 1);
    tick();
    checks++;
    if (wr_ovf !== 1'b0 || wr_ovf !== m_ovf) begin
      errors++; $display("FAIL ovf_clear got %b exp 0", wr_ovf);
    end
    drive(0, 0);
  endtask

  task automatic test_drain();
    rcnt = 3;
    drive(0, 0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (e < 4) begin
        if (full !== 1'b1 || wr_level !== 4'd8) begin
          errors++; $display("FAIL drain_early[%0d] got f %b lvl %0d exp 1 8", e, full, wr_level);
        end
      end else begin
        if (full !== 1'b0 || afull !== 1'b0 || wr_level !== 4'd5) begin
          errors++; $display("FAIL drain_visible got f %b af %b lvl %0d exp 0 0 5", full, afull, wr_level);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    rcnt = 4;
    drive(0, 0);
    repeat (4) tick();
    checks++;
    if (wr_level !== 4'd4) begin
      errors++; $display("FAIL simul_start got %0d exp 4", wr_level);
    end
    rcnt = 5;
    drive(1, 0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      drive(0, 0);
      checks++;
      if (full !== 1'b0 || wr_level !== 4'(m_level)) begin
        errors++; $display("FAIL simul_edge[%0d] got f %b lvl %0d exp f 0 lvl %0d", e, full, wr_level, m_level);
      end
    end
    checks++;
    if (wr_level !== 4'd4) begin
      errors++; $display("FAIL simul_end got %0d exp 4", wr_level);
    end
  endtask

  task automatic test_wrap();
    int accepted = 0;
    bit wrapped = 0;
    bit w, acc;
    logic [AW:0] prev;
    for (int cyc = 0; cyc < 200 && accepted < 20; cyc++) begin
      w = ($urandom % 4) != 0;
      if (rcnt < wcnt && ($urandom % 4) != 0) rcnt++;
      drive(w, 0);
      prev = wr_ptr_gray;
      acc  = w && !m_full;
      tick();
      if (acc) accepted++;
      checks++;
      if ($countones(prev ^ wr_ptr_gray) != (acc ? 1 : 0) || wr_ptr_gray !== gray_of(wcnt)) begin
        errors++; $display("FAIL wrap_gray got %b (prev %b) exp %b", wr_ptr_gray, prev, gray_of(wcnt));
      end
      checks++;
      if (wr_level > 4'd8 || wr_level !== 4'(m_level)) begin
        errors++; $display("FAIL wrap_level got %0d exp %0d", wr_level, m_level);
      end
      if (prev == 4'b1000 && wr_ptr_gray == 4'b0000) wrapped = 1;
    end
    checks++;
    if (accepted != 20 || !wrapped) begin
      errors++; $display("FAIL wrap_done got accepted %0d wrapped %b exp 20 1", accepted, wrapped);
    end
  endtask

  task automatic test_random();
    bit w, c;
    for (int cyc = 0; cyc < 300; cyc++) begin
      w = ($urandom % 2) != 0;
      c = ($urandom % 8) == 0;
      if (rcnt < wcnt && ($urandom % 3) == 0) rcnt++;
      drive(w, c);
      checks++;
      if (mem_we !== (w && !m_full)) begin
        errors++; $display("FAIL rand_we[%0d] got %b exp %b", cyc, mem_we, (w && !m_full));
      end
      tick();
      checks++;
      if (wr_level !== 4'(m_level) || full !== m_full || afull !== m_afull || wr_ovf !== m_ovf ||
          wr_addr !== 3'(wcnt % 8) || wr_ptr_gray !== gray_of(wcnt)) begin
        errors++;
        $display("FAIL rand_state[%0d] got lvl %0d f %b af %b ovf %b addr %0d g %b exp lvl %0d f %b af %b ovf %b addr %0d g %b",
                 cyc, wr_level, full, afull, wr_ovf, wr_addr, wr_ptr_gray,
                 m_level, m_full, m_afull, m_ovf, wcnt % 8, gray_of(wcnt));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
